// File: rtl/level_to_pulse_pkg.sv
// Shared types for the level-to-pulse converter: FSM state encoding and
// counter sizing helper.
package level_to_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Width needed to hold 0..pulse_width without wrapping.
  function automatic int cnt_width(input int pulse_width);
    return $clog2(pulse_width + 1);
  endfunction

endpackage

// File: rtl/l2p_sync.sv
// Optional flop chain in front of the converter FSM; zero stages passes the
// input straight through.
module l2p_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset};
      assign q = d;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] stage_reg;
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        logic stage_in;
        if (gi == 0) begin : g_first
          assign stage_in = d;
        end else begin : g_next
          assign stage_in = stage_reg[gi-1];
        end
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            stage_reg[gi] <= 1'b0;
          end else begin
            stage_reg[gi] <= stage_in;
          end
        end
      end
      assign q = stage_reg[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/level_to_pulse_converter.sv
// Emits one PULSE_WIDTH-cycle pulse per rising edge of the (optionally
// synchronized) level input X; further edges are ignored until X drops.
module level_to_pulse_converter #(
  parameter int PULSE_WIDTH = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic X,
  output logic out
);
  import level_to_pulse_pkg::*;

  localparam int CNT_W = cnt_width(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_WIDTH - 1);

  logic             x_sync;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_reg;

  l2p_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (X),
    .q    (x_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= (state_next == PULSE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (x_sync) begin
          state_next = PULSE;
          cnt_next   = CNT_LOAD;
        end
      end
      PULSE: begin
        // X is deliberately ignored until the count runs out, so a
        // re-rise inside the pulse can neither retrigger nor stretch it.
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = x_sync ? WAIT : IDLE;
        end
      end
      WAIT: begin
        if (!x_sync) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign out = out_reg;

endmodule

// File: tb/tb_level_to_pulse_converter.sv
// Directed bench: three converters (PW=1/SYNC=0, PW=4/SYNC=0, PW=1/SYNC=2)
// share clk, reset and X; expected outputs are hand-computed per edge.
module tb_level_to_pulse_converter;
  import level_to_pulse_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic x;
  logic out_a, out_b, out_c;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  always #5 clk = ~clk;

  level_to_pulse_converter #(.PULSE_WIDTH(1), .SYNC_STAGES(0)) dut_a (
    .clk(clk), .reset(reset), .X(x), .out(out_a)
  );
  level_to_pulse_converter #(.PULSE_WIDTH(4), .SYNC_STAGES(0)) dut_b (
    .clk(clk), .reset(reset), .X(x), .out(out_b)
  );
  level_to_pulse_converter #(.PULSE_WIDTH(1), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .reset(reset), .X(x), .out(out_c)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive X, then look at outputs 1 ns after the edge that sampled it.
  task automatic cyc(input logic xv);
    x = xv;
    @(posedge clk);
    #1;
    $display("t=%0t reset=%b x=%b out_a=%b out_b=%b out_c=%b",
             $time, reset, x, out_a, out_b, out_c);
  endtask

  initial begin
    logic t1_a [5] = '{1, 0, 0, 0, 0};
    logic t1_b [5] = '{1, 1, 1, 1, 0};
    logic t1_c [5] = '{0, 0, 1, 0, 0};
    logic t4_x [8] = '{1, 0, 1, 1, 1, 0, 0, 0};
    logic t4_a [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    logic t4_b [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic t5_a [4] = '{1, 0, 0, 0};
    logic t5_b [4] = '{1, 1, 1, 1};
    logic t5_c [4] = '{0, 0, 1, 0};

    // Reset held low for 16 ns with X low: outputs stay 0.
    reset = 1'b0;
    x     = 1'b0;
    #1;
    chk("rst_t1_a", out_a, 0);
    chk("rst_t1_b", out_b, 0);
    @(posedge clk); #1;
    chk("rst_t6_a", out_a, 0);
    chk("rst_t6_c", out_c, 0);
    @(posedge clk); #1;
    chk("rst_t16_a", out_a, 0);
    chk("rst_state_a", dut_a.state_reg, IDLE);
    chk("rst_cnt_b", dut_b.cnt_reg, 0);
    reset = 1'b1;
    cyc(0);
    chk("idle_a", out_a, 0);

    // Single-cycle X: PW=1 gives 1 cycle, PW=4 gives 4, SYNC=2 is 2 later.
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0);
      chk($sformatf("single_a_%0d", i), out_a, t1_a[i]);
      chk($sformatf("single_b_%0d", i), out_b, t1_b[i]);
      chk($sformatf("single_c_%0d", i), out_c, t1_c[i]);
    end
    repeat (3) cyc(0);

    // X high w / low w for w=1..10: one 1-cycle pulse per rise.
    pulses = 0;
    for (int w = 1; w <= 10; w++) begin
      for (int i = 0; i < w; i++) begin
        cyc(1);
        chk($sformatf("wave_w%0d_hi%0d", w, i), out_a, (i == 0));
        if (out_a === 1'b1) pulses++;
      end
      for (int i = 0; i < w; i++) begin
        cyc(0);
        chk($sformatf("wave_w%0d_lo%0d", w, i), out_a, 0);
        if (out_a === 1'b1) pulses++;
      end
    end
    chk("wave_pulse_count", pulses[7:0], 8'd10);

    // X held high 20 cycles: one pulse, then WAIT until X falls.
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk($sformatf("hold_a_%0d", i), out_a, (i == 0));
      chk($sformatf("hold_b_%0d", i), out_b, (i < 4));
      chk($sformatf("hold_c_%0d", i), out_c, (i == 2));
      if (i > 0) chk($sformatf("hold_state_a_%0d", i), dut_a.state_reg, WAIT);
    end
    cyc(0);
    chk("hold_fall_state_a", dut_a.state_reg, IDLE);
    chk("hold_fall_out_a", out_a, 0);
    repeat (4) cyc(0);

    // Re-rise during a PW=4 pulse: no retrigger; PW=1 sees two pulses.
    for (int i = 0; i < 8; i++) begin
      cyc(t4_x[i]);
      chk($sformatf("rerise_a_%0d", i), out_a, t4_a[i]);
      chk($sformatf("rerise_b_%0d", i), out_b, t4_b[i]);
    end
    repeat (4) cyc(0);

    // Reset mid-pulse clears out at once; X high at release pulses again.
    cyc(1);
    chk("midrst_pre_a", out_a, 1);
    chk("midrst_pre_b", out_b, 1);
    reset = 1'b0;
    #1;
    chk("midrst_now_a", out_a, 0);
    chk("midrst_now_b", out_b, 0);
    chk("midrst_state_b", dut_b.state_reg, IDLE);
    @(posedge clk); #1;
    chk("midrst_held_b", out_b, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk($sformatf("release_a_%0d", i), out_a, t5_a[i]);
      chk($sformatf("release_b_%0d", i), out_b, t5_b[i]);
      chk($sformatf("release_c_%0d", i), out_c, t5_c[i]);
    end
    cyc(0);
    chk("release_b_end", out_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
